// File: rtl/mem_access.sv
// Load/store unit between execute and a single-beat data bus: handles
// non-memory passthrough, misalignment, byte-lane steering, load extension and bus timeout.
module mem_access #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [2:0]  funct3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        reg_w,
  input  logic [31:0] reg_data,
  input  logic [4:0]  rd,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [31:0]   bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [3:0]    bus_be_q, bus_be_d;
  logic          wb_valid_q, wb_valid_d, wb_we_q, wb_we_d, err_q, err_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    lo_q, lo_d;
  logic          load_q, load_d;

  logic          is_byte, is_half, mis;
  logic [3:0]    be;
  logic [31:0]   wdata, b_sh, h_sh, ldata;

  // Size decode: funct3[1:0]==0 byte, ==1 half, anything else is a word.
  always_comb begin
    is_byte = (funct3[1:0] == 2'd0);
    is_half = (funct3[1:0] == 2'd1);
    mis     = is_half ? mem_addr[0] : (!is_byte && (mem_addr[1:0] != 2'd0));
    if (is_byte) begin
      be    = 4'b0001 << mem_addr[1:0];
      wdata = {4{mem_data[7:0]}};
    end else if (is_half) begin
      be    = 4'b0011 << {mem_addr[1], 1'b0};
      wdata = {2{mem_data[15:0]}};
    end else begin
      be    = 4'b1111;
      wdata = mem_data;
    end
  end

  always_comb begin
    b_sh = bus_rdata >> {lo_q, 3'b000};
    h_sh = bus_rdata >> {lo_q[1], 4'b0000};
    case (f3_q[1:0])
      2'd0:    ldata = {{24{~f3_q[2] & b_sh[7]}}, b_sh[7:0]};
      2'd1:    ldata = {{16{~f3_q[2] & h_sh[15]}}, h_sh[15:0]};
      default: ldata = bus_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = 1'b0;
    err_d       = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    f3_d        = f3_q;
    lo_d        = lo_q;
    load_d      = load_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wb_rd_d = rd;
          if (!mem_r && !mem_w) begin
            wb_valid_d = 1'b1;
            wb_we_d    = reg_w;
            wb_data_d  = reg_data;
          end else if (mis) begin
            wb_valid_d = 1'b1;
            err_d      = 1'b1;
            wb_data_d  = '0;
          end else begin
            state_d     = BUS;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_w;
            bus_addr_d  = {mem_addr[31:2], 2'b00};
            bus_be_d    = be;
            bus_wdata_d = wdata;
            f3_d        = funct3;
            lo_d        = mem_addr[1:0];
            load_d      = !mem_w;
          end
        end
      end
      BUS: begin
        // An ack in the final allowed cycle still completes the access.
        if (bus_ack) begin
          bus_req_d  = 1'b0;
          state_d    = RESP;
          wb_valid_d = 1'b1;
          wb_we_d    = load_q;
          wb_data_d  = load_q ? ldata : '0;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          bus_req_d  = 1'b0;
          state_d    = RESP;
          wb_valid_d = 1'b1;
          err_d      = 1'b1;
          wb_data_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      err_q       <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      f3_q        <= '0;
      lo_q        <= '0;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      err_q       <= err_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      f3_q        <= f3_d;
      lo_q        <= lo_d;
      load_q      <= load_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_we     = wb_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: writebacks are predicted into a queue at issue
// time (with their due cycle) and checked by a monitor when wb_valid appears.
module tb_mem_access;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic        mem_r = 1'b0, mem_w = 1'b0, reg_w = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] mem_addr = '0, mem_data = '0, reg_data = '0;
  logic [4:0]  rd = '0;
  logic        bus_req, bus_we, bus_ack = 1'b0;
  logic [31:0] bus_addr, bus_wdata, bus_rdata = '0;
  logic [3:0]  bus_be;
  logic        wb_valid, wb_we, err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int unsigned errors = 0, checks = 0;

  mem_access #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .mem_r(mem_r), .mem_w(mem_w), .funct3(funct3), .mem_addr(mem_addr),
    .mem_data(mem_data), .reg_w(reg_w), .reg_data(reg_data), .rd(rd),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_valid) begin
        if (sb.size() == 0) chk("wb_unexpected", {31'd0, wb_valid}, 32'd0);
        else begin
          mon_e = sb.pop_front();
          chk("wb_cycle", cyc, mon_e.cyc);
          chk("wb_we", {31'd0, wb_we}, {31'd0, mon_e.we});
          chk("wb_err", {31'd0, err}, {31'd0, mon_e.err});
          if (!mon_e.err) chk("wb_rd", {27'd0, wb_rd}, {27'd0, mon_e.rd});
          if (mon_e.we) chk("wb_data", wb_data, mon_e.data);
        end
      end else begin
        chk("err_without_wb", {31'd0, err}, 32'd0);
      end
    end
  end

  // Drives one request; returns at the negedge after accept with req_valid low.
  task automatic issue(input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic rw, input logic [31:0] rdat, input logic [4:0] rdi,
                       input bit push, input logic ewe, input logic eerr,
                       input logic [31:0] edata, input int unsigned lat);
    int unsigned k = 0;
    while (!req_ready && k < 10) begin @(negedge clk); k++; end
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    mem_r = mr; mem_w = mw; funct3 = f3; mem_addr = addr; mem_data = data;
    reg_w = rw; reg_data = rdat; rd = rdi; req_valid = 1'b1;
    if (push) sb.push_back('{ewe, rdi, edata, eerr, cyc + lat});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic bus_fields(input string tag, input logic we, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wd);
    chk({tag, "_req"}, {31'd0, bus_req}, 32'd1);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd0);
    chk({tag, "_we"}, {31'd0, bus_we}, {31'd0, we});
    chk({tag, "_addr"}, bus_addr, addr);
    chk({tag, "_be"}, {28'd0, bus_be}, {28'd0, be});
    if (we) chk({tag, "_wdata"}, bus_wdata, wd);
  endtask

  task automatic bus_txn(input string tag, input int unsigned waits, input logic [31:0] rdata,
                         input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd);
    bus_fields(tag, we, addr, be, wd);
    for (int unsigned i = 0; i < waits; i++) begin
      @(negedge clk);
      bus_fields(tag, we, addr, be, wd);
    end
    bus_ack = 1'b1; bus_rdata = rdata;
    @(negedge clk);
    bus_ack = 1'b0;
    chk({tag, "_req_drop"}, {31'd0, bus_req}, 32'd0);
  endtask

  initial begin
    int unsigned n;
    repeat (2) @(negedge clk);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    rst_n = 1'b1;

    issue(0, 0, 3'd0, 32'h0, 32'h0, 1, 32'h0000_A5A5, 5'd3, 1, 1, 0, 32'h0000_A5A5, 1);
    issue(0, 0, 3'd0, 32'h0, 32'h0, 0, 32'h1234_0000, 5'd4, 1, 0, 0, 32'h0, 1);

    issue(1, 0, 3'd2, 32'h100, 32'h0, 0, 32'h0, 5'd5, 1, 1, 0, 32'hDEAD_BEEF, 5);
    bus_txn("lw", 3, 32'hDEAD_BEEF, 0, 32'h100, 4'hF, 32'h0);

    issue(1, 0, 3'd0, 32'h203, 32'h0, 0, 32'h0, 5'd6, 1, 1, 0, 32'hFFFF_FF80, 2);
    bus_txn("lb", 0, 32'h80FF_FF7F, 0, 32'h200, 4'b1000, 32'h0);
    issue(1, 0, 3'd4, 32'h203, 32'h0, 0, 32'h0, 5'd7, 1, 1, 0, 32'h0000_0080, 3);
    bus_txn("lbu", 1, 32'h80FF_FF7F, 0, 32'h200, 4'b1000, 32'h0);
    issue(1, 0, 3'd1, 32'h202, 32'h0, 0, 32'h0, 5'd8, 1, 1, 0, 32'hFFFF_80FF, 2);
    bus_txn("lh", 0, 32'h80FF_FF7F, 0, 32'h200, 4'b1100, 32'h0);
    issue(1, 0, 3'd5, 32'h202, 32'h0, 0, 32'h0, 5'd9, 1, 1, 0, 32'h0000_80FF, 2);
    bus_txn("lhu", 0, 32'h80FF_FF7F, 0, 32'h200, 4'b1100, 32'h0);

    issue(0, 1, 3'd0, 32'h301, 32'h0000_0012, 0, 32'h0, 5'd10, 1, 0, 0, 32'h0, 4);
    bus_txn("sb", 2, 32'h0, 1, 32'h300, 4'b0010, 32'h1212_1212);
    issue(1, 1, 3'd1, 32'h102, 32'hCAFE_BEEF, 0, 32'h0, 5'd11, 1, 0, 0, 32'h0, 2);
    bus_txn("sh_rw", 0, 32'h0, 1, 32'h100, 4'b1100, 32'hBEEF_BEEF);
    issue(1, 0, 3'd3, 32'h104, 32'h0, 0, 32'h0, 5'd12, 1, 1, 0, 32'h0123_4567, 2);
    bus_txn("f3_3", 0, 32'h0123_4567, 0, 32'h104, 4'hF, 32'h0);

    issue(0, 1, 3'd2, 32'h102, 32'h5555_5555, 0, 32'h0, 5'd13, 1, 0, 1, 32'h0, 1);
    chk("sw_mis_no_req", {31'd0, bus_req}, 32'd0);
    chk("sw_mis_ready", {31'd0, req_ready}, 32'd1);
    issue(1, 0, 3'd1, 32'h201, 32'h0, 0, 32'h0, 5'd14, 1, 0, 1, 32'h0, 1);
    chk("lh_mis_no_req", {31'd0, bus_req}, 32'd0);

    issue(1, 0, 3'd2, 32'h400, 32'h0, 0, 32'h0, 5'd15, 1, 0, 1, 32'h0, TO + 1);
    n = 0;
    while (bus_req && n < 20) begin n++; @(negedge clk); end
    chk("timeout_len", n, TO);
    bus_ack = 1'b1;
    repeat (3) @(negedge clk);
    bus_ack = 1'b0;
    chk("late_ack_no_req", {31'd0, bus_req}, 32'd0);

    issue(1, 0, 3'd2, 32'h500, 32'h0, 0, 32'h0, 5'd16, 0, 0, 0, 32'h0, 0);
    chk("pre_rst_req", {31'd0, bus_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, bus_req}, 32'd0);
    chk("async_rst_addr", bus_addr, 32'd0);
    chk("async_rst_be", {28'd0, bus_be}, 32'd0);
    chk("async_rst_wbv", {31'd0, wb_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    issue(0, 0, 3'd0, 32'h0, 32'h0, 1, 32'h0000_0055, 5'd17, 1, 1, 0, 32'h0000_0055, 1);

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
